barrel_shift_pipe: RTL
======================

# barrel_shift_pipe

Parametrised, pipelined successor to the combinational operand-2 shifter. It performs the ARM LSL/LSR/ASR/ROR/RRX shifts on a WIDTH-bit operand and produces a carry-out. It supports both encoding modes: immediate-amount (5-bit field with ARM's zero-amount aliases) and register-amount (8-bit, values ≥ WIDTH honoured). The block sits between register read and the ALU in the execute path, behind a valid/ready handshake, so a multi-cycle shift can stall issue without losing operands.

## Interface
Parameters:
- WIDTH, 32: operand/result width; power of two, 8..64.
- AMT_W, 8: shift-amount width; must be > log2(WIDTH).
- STAGES, 2: pipeline register stages, 1..3. Latency equals STAGES.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; invalidates every stage.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid is also high.
- op  in  3  0=LSL, 1=LSR, 2=ASR, 3=ROR, 4=RRX; 5..7 act as LSL.
- imm_mode  in  1  1 = immediate-encoded amount, 0 = register amount.
- operand  in  WIDTH  value to shift.
- amount  in  AMT_W  shift amount. Only bits [log2(WIDTH)-1:0] are used when imm_mode=1.
- carry_in  in  1  current CPSR C.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- result  out  WIDTH  shifted value.
- carry_out  out  1  shifter carry.

## Operation
Let v = operand, n = effective amount, W = WIDTH.

Immediate mode (n = amount[log2W-1:0]):
- LSL n=0 → v, c=carry_in.
- LSR n=0 and ASR n=0 are treated as n=W.
- ROR n=0 is executed as RRX.

Register mode and immediate mode after aliasing:
- Any op except RRX with register n=0 → v, c=carry_in.
- LSL:
  - n<W → v<<n, c=v[W-n].
  - n=W → 0, c=v[0].
  - n>W → 0, c=0.
- LSR:
  - n<W → v>>n, c=v[n-1].
  - n=W → 0, c=v[W-1].
  - n>W → 0, c=0.
- ASR:
  - n<W → arithmetic shift, c=v[n-1].
  - n≥W → W copies of v[W-1], c=v[W-1].
- ROR: r = n mod W.
  - r=0 (n≠0) → v, c=v[W-1].
  - otherwise rotate right by r, c=result[W-1].
- RRX: {carry_in, v[W-1:1]}, c=v[0]. The amount is ignored.

Implementation and pipeline:
- Shift network is log2(W) mux levels. The levels are split as evenly as possible across STAGES. Decoded op, carry_in and the out-of-range flags travel with the data.
- Each stage holds a valid bit. Stage k loads when it is empty or stage k+1 loads; the last stage uses out_ready. Bubbles collapse.
- in_ready = stage-0 load condition. It is combinational from out_ready through the stage valids and must not depend on in_valid.

## Timing
- Latency: an operand accepted at edge t appears with out_valid=1 after edge t+STAGES, if there is no back-pressure.
- Throughput: one result per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, result, carry_out and out_valid hold stable. Upstream stages fill, then in_ready falls.
- Simultaneous accept and emit on a full pipe is permitted; no bubble is inserted.
- flush: at the next edge all valids clear and in_ready=1. A request presented in the same cycle as flush is dropped; flush has priority.
- Reset (rst_n low, any time, including mid-stall):
  - Immediately: out_valid=0, result=0, carry_out=0.
  - All stage valids clear and datapath registers go to 0.
  - in_ready=1 once reset deasserts.
- Changing operand/op/amount while in_valid=1 and in_ready=0 is legal. The sampled value is the one present at the accepting edge.

## Test plan
- W=32, register mode, LSL, v=0x8000_0001, n=1 → 0x0000_0002, c=1. n=32 → 0, c=1. n=33 → 0, c=0.
- Immediate mode:
  - LSR amount=0, v=0x8000_0000 → 0, c=1.
  - ASR amount=0, v=0x8000_0000 → 0xFFFF_FFFF, c=1.
  - ROR amount=0, v=0x0000_0003, carry_in=1 → 0x8000_0001, c=1.
- Register ROR:
  - v=0x0000_00F1, n=36 → 0x1000_000F, c=0.
  - n=64 → 0x0000_00F1, c=0.
  - n=0, carry_in=1 → 0x0000_00F1, c=1.
- STAGES=2, back-to-back stream of 8 random ops with out_ready toggling 1,0,0,1... → results in order, none lost or duplicated, each matches the golden model, result stable during stalls.
- Full pipe (out_ready=0 for 5 cycles), then assert flush → out_valid=0 next cycle, in_ready=1, and the next accepted op emerges after exactly STAGES cycles.
- Pulse rst_n low asynchronously mid-stream while out_valid=1 → out_valid, result and carry_out are 0 before the next clk edge. Repeat with WIDTH=16 / AMT_W=6: register LSL n=16, v=0x0001 → 0, c=1.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
// Pipelined ARM operand-2 shifter (LSL/LSR/ASR/ROR/RRX) with valid/ready flow control.
// Every shift is built from one right-shift/rotate network; LSL runs on the bit-reversed operand.
module barrel_shift_pipe #(
    parameter int WIDTH  = 32,
    parameter int AMT_W  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             imm_mode,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    localparam int L = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROR = 3'd3,
        OP_RRX = 3'd4
    } shift_op_e;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int unsigned i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    shift_op_e        opc;
    logic [AMT_W-1:0] n;
    logic [L-1:0]     nl, lsl_idx, rsh_idx;
    logic [WIDTH-1:0] dec_data;
    logic [L-1:0]     dec_amt;
    logic             dec_rot, dec_fill, dec_rev, dec_carry;

    // Carry is resolved here; the network only needs amount, rotate/fill mode and reversal.
    always_comb begin
        opc = (op > 3'd4) ? OP_LSL : shift_op_e'(op);
        n   = imm_mode ? AMT_W'(amount[L-1:0]) : amount;
        if (imm_mode && n == '0) begin
            if (opc == OP_LSR || opc == OP_ASR) n = W_AMT;
            else if (opc == OP_ROR)             opc = OP_RRX;
        end
        nl        = n[L-1:0];
        lsl_idx   = L'(0) - nl;
        rsh_idx   = nl - L'(1);
        dec_data  = operand;
        dec_amt   = '0;
        dec_rot   = 1'b1;
        dec_fill  = 1'b0;
        dec_rev   = 1'b0;
        dec_carry = carry_in;
        if (opc == OP_RRX) begin
            dec_amt   = L'(1);
            dec_rot   = 1'b0;
            dec_fill  = carry_in;
            dec_carry = operand[0];
        end else if (n != '0) begin
            case (opc)
                OP_LSL: begin
                    dec_rot = 1'b0;
                    dec_rev = 1'b1;
                    if (n < W_AMT) begin
                        dec_data  = bit_rev(operand);
                        dec_amt   = nl;
                        dec_carry = operand[lsl_idx];
                    end else begin
                        dec_data  = '0;
                        dec_carry = (n == W_AMT) ? operand[0] : 1'b0;
                    end
                end
                OP_LSR: begin
                    dec_rot = 1'b0;
                    if (n < W_AMT) begin
                        dec_amt   = nl;
                        dec_carry = operand[rsh_idx];
                    end else begin
                        dec_data  = '0;
                        dec_carry = (n == W_AMT) ? operand[WIDTH-1] : 1'b0;
                    end
                end
                OP_ASR: begin
                    dec_rot  = 1'b0;
                    dec_fill = operand[WIDTH-1];
                    if (n < W_AMT) begin
                        dec_amt   = nl;
                        dec_carry = operand[rsh_idx];
                    end else begin
                        dec_data  = {WIDTH{operand[WIDTH-1]}};
                        dec_carry = operand[WIDTH-1];
                    end
                end
                OP_ROR: begin
                    dec_amt   = nl;
                    dec_carry = operand[rsh_idx];
                end
                default: ;
            endcase
        end
    end

    logic [WIDTH-1:0] st_data  [STAGES];
    logic [L-1:0]     st_amt   [STAGES];
    logic             st_rot   [STAGES];
    logic             st_fill  [STAGES];
    logic             st_rev   [STAGES];
    logic             st_carry [STAGES];
    logic [WIDTH-1:0] nx_data  [STAGES];
    logic [L-1:0]     nx_amt   [STAGES];
    logic             nx_rot   [STAGES];
    logic             nx_fill  [STAGES];
    logic             nx_rev   [STAGES];
    logic             nx_carry [STAGES];
    logic [STAGES-1:0] vld, load;
    logic [STAGES:0]   vld_src;
    logic              load_acc;

    // Level k of the network lives in stage (k*STAGES)/L.
    always_comb begin
        for (int unsigned s = 0; s < STAGES; s++) begin
            int unsigned p;
            p = (s == 0) ? 0 : s - 1;
            nx_data[s]  = (s == 0) ? dec_data  : st_data[p];
            nx_amt[s]   = (s == 0) ? dec_amt   : st_amt[p];
            nx_rot[s]   = (s == 0) ? dec_rot   : st_rot[p];
            nx_fill[s]  = (s == 0) ? dec_fill  : st_fill[p];
            nx_rev[s]   = (s == 0) ? dec_rev   : st_rev[p];
            nx_carry[s] = (s == 0) ? dec_carry : st_carry[p];
            for (int unsigned k = 0; k < L; k++) begin
                if ((k * STAGES) / L == s && nx_amt[s][k]) begin
                    nx_data[s] = nx_rot[s]
                        ? ((nx_data[s] >> (1 << k)) | (nx_data[s] << (WIDTH - (1 << k))))
                        : ((nx_data[s] >> (1 << k)) | ({WIDTH{nx_fill[s]}} << (WIDTH - (1 << k))));
                end
            end
            if (s == STAGES - 1 && nx_rev[s]) nx_data[s] = bit_rev(nx_data[s]);
        end
    end

    // A stage loads if it or any stage downstream of it is empty, or the consumer takes the output.
    always_comb begin
        load_acc = out_ready;
        load     = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            load_acc = load_acc | ~vld[STAGES-1-i];
            load[STAGES-1-i] = load_acc;
        end
    end

    assign vld_src = {vld, in_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                st_data[s]  <= '0;
                st_amt[s]   <= '0;
                st_rot[s]   <= 1'b0;
                st_fill[s]  <= 1'b0;
                st_rev[s]   <= 1'b0;
                st_carry[s] <= 1'b0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (flush)        vld[s] <= 1'b0;
                else if (load[s]) vld[s] <= vld_src[s];
                if (load[s]) begin
                    st_data[s]  <= nx_data[s];
                    st_amt[s]   <= nx_amt[s];
                    st_rot[s]   <= nx_rot[s];
                    st_fill[s]  <= nx_fill[s];
                    st_rev[s]   <= nx_rev[s];
                    st_carry[s] <= nx_carry[s];
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld[STAGES-1];
    assign result    = st_data[STAGES-1];
    assign carry_out = st_carry[STAGES-1];

endmodule
